// File: rtl/inst_decode_if.sv
// Handshake and decoded-payload bundle between instruction fetch, inst_decode_stage
// and the register-read/execute stage.
interface inst_decode_if #(
  parameter int INST_W = 26,
  parameter int FUNC_W = 4,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
);
  // valid/ready: a transfer happens on a rising edge where both valid and ready are
  // high; the sender holds valid and payload stable until that edge, and ready may
  // be high or low independently of valid.
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_class;
  logic [3:0]        out_class_oh;
  logic [FUNC_W-1:0] out_func;
  logic [REG_W-1:0]  out_rd;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_class, out_class_oh, out_func,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_class, out_class_oh, out_func,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );
endinterface

// File: rtl/inst_decode_stage.sv
// Pipelined instruction-class decoder: output register plus one-entry skid buffer,
// illegal-encoding flag and saturating per-class retire counters.
// Define DECO_TRACE_EN to print a simulation trace line on every output handshake.
module inst_decode_stage #(
  parameter int INST_W      = 26,
  parameter int FUNC_W      = 4,
  parameter int REG_W       = 4,
  parameter int IMM_W       = 8,
  parameter int DATA_W      = 16,
  parameter int NUM_ALU_OPS = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  inst_decode_if.slave     bus,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_reg,
  output logic [CNT_W-1:0] cnt_br
);

  if (INST_W != 2 + FUNC_W + 3 * REG_W + IMM_W) begin : g_bad_inst_w
    $error("inst_decode_stage: INST_W must equal 2+FUNC_W+3*REG_W+IMM_W");
  end
  if (DATA_W < IMM_W) begin : g_bad_data_w
    $error("inst_decode_stage: DATA_W must be >= IMM_W");
  end

  typedef struct packed {
    logic [1:0]        cls;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [IMM_W-1:0]  imm;
  } raw_t;

  typedef struct packed {
    logic [1:0]        cls;
    logic [3:0]        oh;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic              illegal;
  } dec_t;

  function automatic dec_t decode(input raw_t r);
    dec_t d;
    d.cls  = r.cls;
    d.oh   = 4'b0001 << r.cls;
    d.func = r.func;
    d.rd   = r.rd;
    d.rs1  = r.rs1;
    d.rs2  = r.rs2;
    d.imm  = DATA_W'($signed(r.imm));
    case (r.cls)
      2'b00:   d.illegal = int'(r.func) >= NUM_ALU_OPS;
      2'b01:   d.illegal = r.func > FUNC_W'(1);
      2'b10:   d.illegal = r.imm != '0;
      default: d.illegal = 1'b0;
    endcase
    return d;
  endfunction

  dec_t out_q, skid_q, in_dec;
  logic out_valid_q, skid_valid_q;
  logic accept, drain;
  logic [CNT_W-1:0] cnt_q [4];

  assign in_dec       = decode(bus.in_inst);
  assign bus.in_ready = !skid_valid_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;

  // The skid only fills when the output register is stalled, so it always drains first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= in_dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_dec;
      skid_valid_q <= 1'b1;
    end
  end

  // Clear beats a same-cycle handshake; a handshake during flush still retires.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (drain && cnt_q[out_q.cls] != '1) begin
      cnt_q[out_q.cls] <= cnt_q[out_q.cls] + 1'b1;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_class    = out_q.cls;
  assign bus.out_class_oh = out_q.oh;
  assign bus.out_func     = out_q.func;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_illegal  = out_q.illegal;

  assign cnt_alu = cnt_q[0];
  assign cnt_mem = cnt_q[1];
  assign cnt_reg = cnt_q[2];
  assign cnt_br  = cnt_q[3];

`ifdef DECO_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && drain) begin
      case (out_q.cls)
        2'b00:   $write("operacion de tipo Logico-Aritmetica");
        2'b01:   $write("operacion de tipo Memoria");
        2'b10:   $write("operacion de tipo Registro");
        default: $write("operacion de tipo Branch");
      endcase
      $display(" func=%0d rd=%0d rs1=%0d rs2=%0d imm=%0h%s", out_q.func, out_q.rd,
               out_q.rs1, out_q.rs2, out_q.imm, out_q.illegal ? " ILEGAL" : "");
    end
  end
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: vector table, directed multi-cycle sequences and
// random traffic checked against a field-level reference model.
module tb_inst_decode_stage;
  localparam int W = 39;

  logic clk = 1'b0;
  logic rst, flush, cnt_clr;
  logic [15:0] cnt_alu, cnt_mem, cnt_reg, cnt_br;
  int total = 0;
  int bad = 0;

  inst_decode_if #(.INST_W(26), .FUNC_W(4), .REG_W(4), .DATA_W(16)) intf ();

  inst_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr), .bus(intf),
    .cnt_alu(cnt_alu), .cnt_mem(cnt_mem), .cnt_reg(cnt_reg), .cnt_br(cnt_br)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_word();
    return {intf.out_class, intf.out_class_oh, intf.out_func, intf.out_rd,
            intf.out_rs1, intf.out_rs2, intf.out_imm, intf.out_illegal};
  endfunction

  // reference decode straight from the field rules
  function automatic logic [W-1:0] model(input logic [25:0] inst);
    int v, cls, func, rd, rs1, rs2, imm, imm16;
    bit ill;
    v     = int'(inst);
    cls   = v / 16777216;
    func  = (v / 1048576) % 16;
    rd    = (v / 65536) % 16;
    rs1   = (v / 4096) % 16;
    rs2   = (v / 256) % 16;
    imm   = v % 256;
    imm16 = (imm >= 128) ? imm + 65280 : imm;
    ill   = (cls == 0 && func >= 10) || (cls == 1 && func > 1) || (cls == 2 && imm != 0);
    return {2'(cls), 4'(1 << cls), 4'(func), 4'(rd), 4'(rs1), 4'(rs2), 16'(imm16), ill};
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int m_cnt[4];
  bit pend = 0;
  logic [W-1:0] held;

  always @(negedge clk) begin
    logic [W-1:0] e;
    bit hs;
    int c;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      pend = 0;
    end else begin
      check("cnt_alu", 64'(cnt_alu), 64'(m_cnt[0]));
      check("cnt_mem", 64'(cnt_mem), 64'(m_cnt[1]));
      check("cnt_reg", 64'(cnt_reg), 64'(m_cnt[2]));
      check("cnt_br", 64'(cnt_br), 64'(m_cnt[3]));
      if (pend) begin
        check("hold_valid", 64'(intf.out_valid), 64'(1));
        check("hold_payload", 64'(dut_word()), 64'(held));
      end
      pend = intf.out_valid && !intf.out_ready && !flush;
      held = dut_word();
      hs = 0;
      c = 0;
      if (intf.out_valid && intf.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected actual=%0h expected=none at %0t", dut_word(), $time);
        end else begin
          e = exp_q.pop_front();
          check("out_payload", 64'(dut_word()), 64'(e));
          hs = 1;
          c = int'(e[W-1 -: 2]);
        end
      end
      if (cnt_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      else if (hs && m_cnt[c] < 65535) m_cnt[c]++;
      if (flush) exp_q.delete();
      else if (intf.in_valid && intf.in_ready) exp_q.push_back(model(intf.in_inst));
    end
  end

  typedef struct {
    logic [25:0]  inst;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0] c2;
    logic [25:0] r;
    vecs[0] = '{26'h03123FF, {2'd0, 4'b0001, 4'h3, 4'h1, 4'h2, 4'h3, 16'hFFFF, 1'b0}};
    vecs[1] = '{26'h0C56710, {2'd0, 4'b0001, 4'hC, 4'h5, 4'h6, 4'h7, 16'h0010, 1'b1}};
    vecs[2] = '{26'h0912345, {2'd0, 4'b0001, 4'h9, 4'h1, 4'h2, 4'h3, 16'h0045, 1'b0}};
    vecs[3] = '{26'h0A00080, {2'd0, 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0, 16'hFF80, 1'b1}};
    vecs[4] = '{26'h1234567, {2'd1, 4'b0010, 4'h2, 4'h3, 4'h4, 4'h5, 16'h0067, 1'b1}};
    vecs[5] = '{26'h11ABC7F, {2'd1, 4'b0010, 4'h1, 4'hA, 4'hB, 4'hC, 16'h007F, 1'b0}};
    vecs[6] = '{26'h2000001, {2'd2, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0001, 1'b1}};
    vecs[7] = '{26'h2F12300, {2'd2, 4'b0100, 4'hF, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b0}};
    vecs[8] = '{26'h3F00000, {2'd3, 4'b1000, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0}};
    vecs[9] = '{26'h3E98781, {2'd3, 4'b1000, 4'hE, 4'h9, 4'h8, 4'h7, 16'hFF81, 1'b0}};

    intf.in_valid = 0; intf.in_inst = '0; intf.out_ready = 0;
    flush = 0; cnt_clr = 0; rst = 1;
    repeat (3) step();
    check("rst_out_valid", 64'(intf.out_valid), 64'(0));
    check("rst_in_ready", 64'(intf.in_ready), 64'(0));
    check("rst_payload", 64'(dut_word()), 64'(0));
    check("rst_counters", {cnt_alu, cnt_mem, cnt_reg, cnt_br}, 64'(0));
    rst = 0;
    step();
    check("post_rst_in_ready", 64'(intf.in_ready), 64'(1));

    // table vectors, streamed with out_ready high
    intf.out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      intf.in_valid = 1;
      intf.in_inst = vecs[i].inst;
      step();
      check($sformatf("vec%0d_valid", i), 64'(intf.out_valid), 64'(1));
      check($sformatf("vec%0d", i), 64'(dut_word()), 64'(vecs[i].exp));
    end
    intf.in_valid = 0;
    step();
    check("vec_drained", 64'(intf.out_valid), 64'(0));
    check("vec_counts", {cnt_alu, cnt_mem, cnt_reg, cnt_br},
          {16'd4, 16'd2, 16'd2, 16'd2});

    cnt_clr = 1;
    step();
    cnt_clr = 0;
    check("clr_counts", {cnt_alu, cnt_mem, cnt_reg, cnt_br}, 64'(0));

    // back-to-back, one per class, no bubbles
    for (int i = 0; i < 4; i++) begin
      c2 = 2'(i);
      intf.in_valid = 1;
      intf.in_inst = {c2, 4'h0, 4'(i), 16'h0000};
      step();
      check($sformatf("b2b%0d_valid", i), 64'(intf.out_valid), 64'(1));
      check($sformatf("b2b%0d_class", i), 64'(intf.out_class), 64'(i));
    end
    intf.in_valid = 0;
    step();
    check("b2b_counts", {cnt_alu, cnt_mem, cnt_reg, cnt_br},
          {16'd1, 16'd1, 16'd1, 16'd1});

    // stall: output + skid fill, third word held off
    intf.out_ready = 0;
    intf.in_valid = 1;
    intf.in_inst = {2'd3, 4'h0, 4'h1, 16'h0000};
    step();
    check("stall_ready1", 64'(intf.in_ready), 64'(1));
    intf.in_inst = {2'd3, 4'h0, 4'h2, 16'h0000};
    step();
    check("stall_ready2", 64'(intf.in_ready), 64'(0));
    check("stall_rd_a", 64'(intf.out_rd), 64'(1));
    intf.in_inst = {2'd3, 4'h0, 4'h3, 16'h0000};
    step();
    check("stall_ready3", 64'(intf.in_ready), 64'(0));
    check("stall_hold_a", 64'(intf.out_rd), 64'(1));
    intf.out_ready = 1;
    step();
    check("stall_rd_b", 64'(intf.out_rd), 64'(2));
    check("stall_ready_back", 64'(intf.in_ready), 64'(1));
    step();
    check("stall_rd_c", 64'(intf.out_rd), 64'(3));
    intf.in_valid = 0;
    step();
    check("stall_drained", 64'(intf.out_valid), 64'(0));

    // branch counter saturation, then clear racing a handshake
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    intf.in_valid = 1;
    intf.in_inst = 26'h3000000;
    repeat (65535) step();
    intf.in_valid = 0;
    repeat (2) step();
    check("sat_full", 64'(cnt_br), 64'(16'hFFFF));
    intf.in_valid = 1;
    step();
    intf.in_valid = 0;
    repeat (2) step();
    check("sat_hold", 64'(cnt_br), 64'(16'hFFFF));
    intf.in_valid = 1;
    step();
    intf.in_valid = 0;
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    check("clr_beats_hs", 64'(cnt_br), 64'(0));
    step();

    // flush with output and skid both full
    intf.out_ready = 0;
    intf.in_valid = 1;
    intf.in_inst = 26'h1000000;
    repeat (2) step();
    flush = 1;
    intf.in_inst = 26'h2000000;
    step();
    flush = 0;
    intf.in_valid = 0;
    check("flush_out_valid", 64'(intf.out_valid), 64'(0));
    check("flush_in_ready", 64'(intf.in_ready), 64'(1));
    check("flush_counts", {cnt_alu, cnt_mem, cnt_reg, cnt_br}, 64'(0));
    step();
    check("flush_stays_empty", 64'(intf.out_valid), 64'(0));

    // flush with a drain and an accept in the same cycle
    intf.in_valid = 1;
    intf.in_inst = 26'h1000000;
    step();
    intf.out_ready = 1;
    flush = 1;
    intf.in_inst = 26'h2000000;
    step();
    flush = 0;
    intf.in_valid = 0;
    intf.out_ready = 0;
    check("flush_hs_valid", 64'(intf.out_valid), 64'(0));
    check("flush_hs_counts", {cnt_alu, cnt_mem, cnt_reg, cnt_br},
          {16'd0, 16'd1, 16'd0, 16'd0});
    step();
    check("flush_discard", 64'(intf.out_valid), 64'(0));

    // reset mid-stream
    intf.in_valid = 1;
    intf.in_inst = 26'h3A12345;
    repeat (2) step();
    rst = 1;
    step();
    check("mrst_out_valid", 64'(intf.out_valid), 64'(0));
    check("mrst_in_ready", 64'(intf.in_ready), 64'(0));
    check("mrst_payload", 64'(dut_word()), 64'(0));
    check("mrst_counters", {cnt_alu, cnt_mem, cnt_reg, cnt_br}, 64'(0));
    step();
    check("mrst_in_ready2", 64'(intf.in_ready), 64'(0));
    rst = 0;
    intf.in_valid = 0;
    step();
    check("mrst_release", 64'(intf.in_ready), 64'(1));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = 26'($urandom);
      intf.in_valid  = ($urandom_range(0, 9) < 7);
      intf.in_inst   = r;
      intf.out_ready = ($urandom_range(0, 9) < 6);
      flush          = ($urandom_range(0, 99) == 0);
      cnt_clr        = ($urandom_range(0, 99) == 0);
      step();
    end
    intf.in_valid = 0;
    flush = 0;
    cnt_clr = 0;
    intf.out_ready = 1;
    repeat (4) step();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
